// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arbOwner_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Memory-handshake watchdog: counts BUSY cycles without m_ready and flags
// expiry on the cycle the count would reach TIMEOUT.
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] wdCnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wdCnt <= 8'd0;
    end else if (en) begin
      wdCnt <= wdCnt + 8'd1;
    end
  end

  assign expire = en && (wdCnt == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data
// access; data wins unless fetch has lost STARVE_MAX grants in a row.
//
// state    | meaning
// ARB_IDLE | no transaction; grant decision taken this cycle
// ARB_BUSY | m_req held with latched command until m_ready or watchdog
// ARB_RESP | one-cycle done pulse to the owner; no grant here
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_be,
  input  logic          m_ready,
  input  logic [31:0]   m_rdata,
  output logic          err
);
  import mem_port_arbiter_pkg::*;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  arbState_t  state, nextState;
  arbOwner_t  own;
  logic [3:0] starveCnt;
  logic       grantD, grantI;
  logic       wdExpire;

  mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != ARB_BUSY),
    .en     ((state == ARB_BUSY) && !m_ready),
    .expire (wdExpire)
  );

  always_comb begin
    nextState = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_req && (!if_req || (starveCnt < STARVE_LIMIT))) begin
          grantD = 1'b1;
        end else if (if_req) begin
          grantI = 1'b1;
        end
        if (grantD || grantI) nextState = ARB_BUSY;
      end
      ARB_BUSY: if (m_ready || wdExpire) nextState = ARB_RESP;
      ARB_RESP: nextState = ARB_IDLE;
      default:  nextState = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      own       <= OWN_I;
      starveCnt <= 4'd0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= 32'h0;
      m_be      <= 4'h0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
      err       <= 1'b0;
    end else begin
      state <= nextState;
      if (grantD) begin
        own     <= OWN_D;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
        if (if_req && (starveCnt != STARVE_LIMIT)) starveCnt <= starveCnt + 4'd1;
      end else if (grantI) begin
        own       <= OWN_I;
        m_we      <= 1'b0;
        m_addr    <= if_addr;
        m_wdata   <= 32'h0;
        m_be      <= FETCH_BE;
        starveCnt <= 4'd0;
      end
      // An aborted access returns zero data to the owner; stores never touch d_rdata.
      if ((state == ARB_BUSY) && (m_ready || wdExpire)) begin
        if (wdExpire) err <= 1'b1;
        if (own == OWN_I) begin
          if_rdata <= m_ready ? m_rdata : 32'h0;
        end else if (!m_we) begin
          d_rdata <= m_ready ? m_rdata : 32'h0;
        end
      end
    end
  end

  assign m_req    = (state == ARB_BUSY);
  assign if_done  = (state == ARB_RESP) && (own == OWN_I);
  assign d_done   = (state == ARB_RESP) && (own == OWN_D);
  assign if_stall = if_req && !if_done;
  assign d_stall  = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them against each done pulse.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        err;

  mem_port_arbiter #(.AW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isD;
    logic [31:0] rdata;
    int          cyc;
    logic        errv;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busyCnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memData(logic [31:0] a);
    case (a)
      32'h0000_0040: memData = 32'h2008_0005;
      32'h0000_1000: memData = 32'hCAFE_0001;
      default:       memData = 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  function automatic int memWait(logic [31:0] a);
    case (a)
      32'h0000_1000, 32'h0000_1500: memWait = 3;
      32'h0000_2000:                memWait = 1000;
      default:                      memWait = 0;
    endcase
  endfunction

  // Memory model: m_ready after memWait BUSY cycles, junk data while not ready.
  always @(negedge clk) begin
    if (m_req) begin
      if (busyCnt >= memWait(m_addr)) begin
        m_ready = 1'b1;
        m_rdata = memData(m_addr);
      end else begin
        m_ready = 1'b0;
        m_rdata = 32'hBAD0_BAD0;
      end
      busyCnt++;
    end else begin
      busyCnt = 0;
      m_ready = 1'b0;
      m_rdata = 32'hBAD0_BAD0;
    end
  end

  always @(negedge clk) begin
    if (!rst && (if_done || d_done)) begin
      checks++;
      if (if_done && d_done) begin
        errors++;
        $display("FAIL both_done: if_done=%0b d_done=%0b required one-hot", if_done, d_done);
      end else if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: if_done=%0b d_done=%0b at cycle %0d", if_done, d_done, cyc);
      end else begin
        exp_t e;
        logic [31:0] got;
        e = expQ.pop_front();
        got = d_done ? d_rdata : if_rdata;
        if (d_done != e.isD || got != e.rdata || cyc != e.cyc || err != e.errv) begin
          errors++;
          $display("FAIL done_%s: got isD=%0b rdata=%h cyc=%0d err=%0b, required isD=%0b rdata=%h cyc=%0d err=%0b",
                   e.isD ? "d" : "if", d_done, got, cyc, err, e.isD, e.rdata, e.cyc, e.errv);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic isD, input logic [31:0] rdata, input int c, input logic e);
    exp_t x;
    x.isD = isD; x.rdata = rdata; x.cyc = c; x.errv = e;
    expQ.push_back(x);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_done || d_done) && n < 40);
    if (!(if_done || d_done)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 40 cycles, required a done pulse", name);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    m_ready = 1'b0; m_rdata = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_done", {30'h0, if_done, d_done}, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    chk("rst_m_fields", m_addr | m_wdata | {27'h0, m_we, m_be}, 32'h0);
    tick();

    // Single zero-wait fetch
    if_req = 1'b1; if_addr = 32'h0000_0040;
    k = cyc;
    pushExp(1'b0, 32'h2008_0005, k + 2, 1'b0);
    tick();
    chk("fetch_m_req", 32'(m_req), 32'h1);
    chk("fetch_m_addr", m_addr, 32'h0000_0040);
    chk("fetch_m_we_be", {27'h0, m_we, m_be}, 32'h0000_000F);
    chk("fetch_stall_busy", 32'(if_stall), 32'h1);
    tick();
    chk("fetch_done_cycle", 32'(if_done), 32'h1);
    chk("fetch_stall_done", 32'(if_stall), 32'h0);
    chk("fetch_m_req_resp", 32'(m_req), 32'h0);
    if_req = 1'b0;
    tick();
    chk("fetch_m_req_idle", 32'(m_req), 32'h0);

    // Simultaneous: data load (3 waits) first, then zero-wait fetch
    if_req = 1'b1; if_addr = 32'h0000_0044;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1000; d_be = 4'hF;
    k = cyc;
    pushExp(1'b1, 32'hCAFE_0001, k + 5, 1'b0);
    pushExp(1'b0, 32'hA5A5_0044, k + 8, 1'b0);
    tick();
    chk("sim_d_first", m_addr, 32'h0000_1000);
    chk("sim_stalls", {30'h0, if_stall, d_stall}, 32'h3);
    waitDone("sim_d");
    d_req = 1'b0;
    waitDone("sim_i");
    if_req = 1'b0;
    tick();

    // Starvation guard: four data grants, fifth goes to fetch
    if_req = 1'b1; if_addr = 32'h0000_0048;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    k = cyc;
    for (int i = 0; i < 4; i++) pushExp(1'b1, 32'hA5A5_0300, k + 2 + 3 * i, 1'b0);
    pushExp(1'b0, 32'hA5A5_0048, k + 14, 1'b0);
    for (int i = 0; i < 5; i++) waitDone("starve");
    if_req = 1'b0; d_req = 1'b0;
    chk("starve_cnt_cleared", 32'(dut.starveCnt), 32'h0);
    tick();

    // Store with 3 wait cycles: command stable, d_rdata untouched
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1500;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    k = cyc;
    pushExp(1'b1, 32'hA5A5_0300, k + 5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("store_m_req", 32'(m_req), 32'h1);
      chk("store_m_we_be", {27'h0, m_we, m_be}, 32'h0000_0013);
      chk("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
    end
    waitDone("store");
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Watchdog: memory never ready, TIMEOUT=8
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_be = 4'hF;
    k = cyc;
    pushExp(1'b1, 32'h0000_0000, k + 9, 1'b1);
    waitDone("timeout");
    d_req = 1'b0;
    repeat (3) tick();
    chk("err_sticky", 32'(err), 32'h1);
    chk("err_idle_m_req", 32'(m_req), 32'h0);

    // Reset during the second BUSY cycle abandons the transaction
    if_req = 1'b1; if_addr = 32'h0000_2000;
    tick();
    tick();
    chk("rstbusy_in_busy", 32'(m_req), 32'h1);
    rst = 1'b1;
    if_req = 1'b0;
    tick();
    chk("rstbusy_m_req", 32'(m_req), 32'h0);
    chk("rstbusy_state", 32'(dut.state), 32'(ARB_IDLE));
    chk("rstbusy_err", 32'(err), 32'h0);
    chk("rstbusy_done", {30'h0, if_done, d_done}, 32'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rstbusy_no_done", {30'h0, if_done, d_done}, 32'h0);
    chk("queue_drained", 32'(expQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
